// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice LSB first; result and flags are registered on entering DONE.
// Latency is WIDTH+1 cycles from start to done; there is no backpressure, and start is ignored while busy.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_ctr,
    input  logic             slice_res,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [2:0]       op_reg;
    logic [IW-1:0]    idx;
    logic             cy;
    logic             cy_msb_in;
    logic             last_bit;
    logic             msb_in_bit;
    logic             arith;

    assign last_bit   = (idx == IW'(WIDTH - 1));
    assign msb_in_bit = (idx == IW'(WIDTH - 2));
    assign arith      = (op_reg[1:0] == 2'b10);

    // Final bit must land in the registered result on the same edge that enters DONE.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = slice_res;
    end

    assign slice_a   = busy & a_reg[idx];
    assign slice_b   = busy & b_reg[idx];
    assign slice_cin = busy & cy;
    assign slice_ctr = op_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            op_reg    <= 3'b000;
            idx       <= '0;
            cy        <= 1'b0;
            cy_msb_in <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        op_reg    <= op;
                        acc       <= '0;
                        idx       <= '0;
                        cy        <= op[2];
                        cy_msb_in <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cy  <= slice_cout;
                    idx <= idx + IW'(1);
                    if (msb_in_bit) begin
                        cy_msb_in <= slice_cout;
                    end
                    if (last_bit) begin
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        result   <= acc_next;
                        zero     <= (acc_next == '0);
                        carry    <= arith & slice_cout;
                        overflow <= arith & (cy_msb_in ^ slice_cout);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial ALU sequencer that drives one 1-bit ALU slice across a full operand, one bit per cycle, LSB first. It latches two WIDTH-bit operands and a 3-bit slice control word, feeds bit i of each operand plus the registered carry into the slice, and collects the slice's result and carry-out bits. When the pass completes, it produces the WIDTH-bit result plus zero/carry/overflow flags. It sits directly around the 1-bit slice: it is the slice's only driver and its only consumer, replacing a WIDTH-wide ripple array where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- op  in  3  slice control, latched on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high in DONE
- result  out  WIDTH  registered result, valid from done, held until next done
- zero  out  1  result == 0
- carry  out  1  final slice carry-out; forced 0 unless op[1:0]==2'b10
- overflow  out  1  signed overflow; forced 0 unless op[1:0]==2'b10
- slice_a  out  1  bit to slice input a
- slice_b  out  1  bit to slice input b
- slice_cin  out  1  carry to slice
- slice_ctr  out  3  control to slice (latched op)
- slice_res  in  1  slice result bit
- slice_cout  in  1  slice carry-out

## Operation
- Slice contract (combinational): b' = b ^ ctr[2]. ctr[1:0] selects: 00 → a&b', 01 → a|b', 10 → a^b'^cin, 11 → a^b'. cout = a&b' | (a^b')&cin.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE with start=1 → latch a, b, op; idx←0; cy←op[2]; go to RUN.
- IDLE with start=0 → stay.
- RUN:
  - slice_a=a_reg[idx], slice_b=b_reg[idx], slice_cin=cy, slice_ctr=op_reg.
  - Each cycle: shift slice_res into the result accumulator at bit idx; cy←slice_cout; idx←idx+1.
  - When idx==WIDTH-2, capture cy_msb_in←slice_cout (the carry into the MSB).
  - When idx==WIDTH-1, go to DONE after the capture.
- Entering DONE: result←accumulator; zero←(accumulator==0); carry←cy (gated); overflow←cy_msb_in ^ cy (gated).
- DONE: done=1 for exactly one cycle.
  - start=1 → accepted exactly as in IDLE; go to RUN (back-to-back).
  - start=0 → go to IDLE.
- start in RUN is ignored. Operands are not re-sampled.
- op[2]=1 with op[1:0]=10 gives subtraction a−b (two's complement, cin=1). carry=1 means no borrow.
- Outside RUN, slice_a, slice_b and slice_cin are 0; slice_ctr holds op_reg.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, busy=0, done=0.
  - result=0, zero=0, carry=0, overflow=0.
  - all slice_* outputs 0, internal regs 0.
- Start accepted at edge T0 → RUN occupies cycles T0+1 … T0+WIDTH → done high in cycle T0+WIDTH+1. Latency is WIDTH+1 cycles, start to done.
- Throughput: one operation per WIDTH+1 cycles with back-to-back start held high in DONE.
- Outputs are registered. result and flags change only on the edge entering DONE (or on reset).
- Reset mid-RUN aborts the operation. No done is issued. result keeps its reset value 0.

## Test plan
- Add, WIDTH=32: a=5, b=3, op=3'b010, start one cycle → busy for 32 cycles; done 33 cycles after start; result=8, zero=0, carry=0, overflow=0.
- Subtract: a=3, b=5, op=3'b110 → result=32'hFFFFFFFE, carry=0, overflow=0. Then a=b=32'h1234, op=3'b110 → result=0, zero=1, carry=1.
- Overflow: a=32'h7FFFFFFF, b=1, op=3'b010 → result=32'h80000000, overflow=1, carry=0. Then a=b=32'h80000000 → result=0, zero=1, carry=1, overflow=1.
- Logic ops on a=32'hF0F0_00FF, b=32'h0FF0_0F0F:
  - op=000 → 32'h00F0_000F
  - op=001 → 32'hFFF0_0FFF
  - op=011 → 32'hFF00_0FF0
  - carry=0 and overflow=0 for all three.
- Protocol:
  - start pulsed again mid-RUN with different operands → ignored; first result returned.
  - start held high through DONE → second op begins; its done arrives exactly 33 cycles after the first.
- Reset: assert rst_n=0 at RUN cycle 10 → busy, done and all outputs 0 immediately (asynchronously). After release, no done until a new start; a fresh add 1+1 → result=2.
